// File: rtl/mtimer.sv
// rtl/mtimer.sv - memory-mapped 64-bit machine timer with prescaler, compare and interrupt
module mtimer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_2000,
    parameter int          PRESC_W   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  mem_mode,
    output logic        hit,
    output logic [31:0] rdata,
    output logic        timer_irq
);

    localparam logic [2:0] OFF_MTIME_LO = 3'd0;
    localparam logic [2:0] OFF_MTIME_HI = 3'd1;
    localparam logic [2:0] OFF_CMP_LO   = 3'd2;
    localparam logic [2:0] OFF_CMP_HI   = 3'd3;
    localparam logic [2:0] OFF_CTRL     = 3'd4;
    localparam logic [2:0] OFF_PRESC    = 3'd5;
    localparam logic [2:0] OFF_STATUS   = 3'd6;

    logic [63:0]        mtime;
    logic [63:0]        mtimecmp;
    logic [31:0]        shadow;
    logic               en;
    logic               ie;
    logic               berr;
    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] pcnt;

    logic        legal;
    logic        illegal;
    logic        wr;
    logic        rd;
    logic [2:0]  off;
    logic        pend;
    logic        tick;
    logic [31:0] presc_ext;
    logic [31:0] reg_val;

    assign hit     = (addr[31:5] == BASE_ADDR[31:5]);
    assign legal   = hit && (mem_mode == 3'b010) && (addr[1:0] == 2'b00);
    assign illegal = hit && (rd_en || wr_en) && !legal;
    assign wr      = wr_en && legal;
    assign rd      = rd_en && legal;
    assign off     = addr[4:2];
    assign pend    = (mtime >= mtimecmp);
    assign tick    = en && (pcnt == presc);

    always_comb begin
        presc_ext = '0;
        presc_ext[PRESC_W-1:0] = presc;
    end

    // MTIME_HI reads the shadow so a LO-then-HI pair sees one consistent value
    always_comb begin
        reg_val = '0;
        case (off)
            OFF_MTIME_LO: reg_val = mtime[31:0];
            OFF_MTIME_HI: reg_val = shadow;
            OFF_CMP_LO:   reg_val = mtimecmp[31:0];
            OFF_CMP_HI:   reg_val = mtimecmp[63:32];
            OFF_CTRL:     reg_val = {30'd0, ie, en};
            OFF_PRESC:    reg_val = presc_ext;
            OFF_STATUS:   reg_val = {30'd0, berr, pend};
            default:      reg_val = '0;
        endcase
    end

    assign rdata = rd ? reg_val : 32'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime     <= '0;
            mtimecmp  <= '1;
            shadow    <= '0;
            en        <= 1'b0;
            ie        <= 1'b0;
            berr      <= 1'b0;
            presc     <= '0;
            pcnt      <= '0;
            timer_irq <= 1'b0;
        end else begin
            timer_irq <= ie && pend;

            if (illegal)
                berr <= 1'b1;
            else if (wr && off == OFF_STATUS && wdata[1])
                berr <= 1'b0;

            if (rd && off == OFF_MTIME_LO)
                shadow <= mtime[63:32];

            if (wr && (off == OFF_CTRL || off == OFF_PRESC))
                pcnt <= '0;
            else if (!en || tick)
                pcnt <= '0;
            else
                pcnt <= pcnt + PRESC_W'(1);

            // A software write to either mtime word wins over a coincident tick
            if (wr && off == OFF_MTIME_LO) begin
                mtime[31:0] <= wdata;
            end else if (wr && off == OFF_MTIME_HI) begin
                mtime[63:32] <= wdata;
                shadow       <= wdata;
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end

            if (wr && off == OFF_CMP_LO)
                mtimecmp[31:0] <= wdata;
            if (wr && off == OFF_CMP_HI)
                mtimecmp[63:32] <= wdata;

            if (wr && off == OFF_CTRL) begin
                en <= wdata[0];
                ie <= wdata[1];
            end

            if (wr && off == OFF_PRESC)
                presc <= wdata[PRESC_W-1:0];
        end
    end

endmodule

// File: tb/tb_mtimer.sv
// tb/tb_mtimer.sv - scoreboard testbench for mtimer
module tb_mtimer;

    localparam logic [31:0] BASE = 32'h0000_2000;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  mem_mode;
    logic        hit;
    logic [31:0] rdata;
    logic        timer_irq;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic        hit;
    } exp_t;

    exp_t sb[$];

    mtimer #(.BASE_ADDR(BASE), .PRESC_W(16)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .addr(addr),
        .wdata(wdata), .mem_mode(mem_mode), .hit(hit), .rdata(rdata),
        .timer_irq(timer_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reads are combinational: sample mid-cycle while the request is still driven
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rd_en) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check(e.tag, {32'd0, rdata}, {32'd0, e.data});
                check({e.tag, "_hit"}, {63'd0, hit}, {63'd0, e.hit});
            end
        end
    end

    task automatic bus(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] m);
        @(negedge clk);
        rd_en = r; wr_en = w; addr = a; wdata = d; mem_mode = m;
        @(posedge clk);
        #1;
        rd_en = 1'b0; wr_en = 1'b0;
    endtask

    task automatic wr_reg(input logic [2:0] o, input logic [31:0] d);
        bus(1'b0, 1'b1, BASE + {27'd0, o, 2'b00}, d, 3'b010);
    endtask

    task automatic rd_any(input string tag, input logic [31:0] a, input logic [2:0] m,
                          input logic [31:0] exp, input logic exp_hit);
        exp_t e;
        e.tag = tag; e.data = exp; e.hit = exp_hit;
        sb.push_back(e);
        bus(1'b1, 1'b0, a, 32'd0, m);
    endtask

    task automatic rd_reg(input string tag, input logic [2:0] o, input logic [31:0] exp);
        rd_any(tag, BASE + {27'd0, o, 2'b00}, 3'b010, exp, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rst_vals [8];
        rst_vals = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0};
        rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; addr = '0; wdata = '0; mem_mode = 3'b010;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("irq_reset", {63'd0, timer_irq}, 64'd0);
        for (int i = 0; i < 8; i++)
            rd_reg($sformatf("reset_off%0d", i), 3'(i), rst_vals[i]);
        wr_reg(3'd7, 32'hDEAD_BEEF);
        rd_reg("reserved_wr", 3'd7, 32'd0);

        // prescaled counting
        wr_reg(3'd5, 32'd3);
        wr_reg(3'd4, 32'd1);
        idle(12);
        rd_reg("presc3_12cyc", 3'd0, 32'd3);
        wr_reg(3'd4, 32'd0);
        wr_reg(3'd0, 32'd0);
        wr_reg(3'd1, 32'd0);
        wr_reg(3'd5, 32'd0);
        wr_reg(3'd4, 32'd1);
        idle(10);
        rd_reg("presc0_10cyc", 3'd0, 32'd10);

        // compare and interrupt
        wr_reg(3'd4, 32'd0);
        wr_reg(3'd0, 32'd0);
        wr_reg(3'd1, 32'd0);
        wr_reg(3'd3, 32'd0);
        wr_reg(3'd2, 32'd5);
        wr_reg(3'd4, 32'd3);
        idle(4);
        rd_reg("pend_before", 3'd6, 32'd0);
        check("irq_before", {63'd0, timer_irq}, 64'd0);
        rd_reg("pend_at5", 3'd6, 32'd1);
        check("irq_after_pend", {63'd0, timer_irq}, 64'd1);
        wr_reg(3'd2, 32'd100);
        check("irq_cmp_edge", {63'd0, timer_irq}, 64'd1);
        idle(1);
        check("irq_cleared", {63'd0, timer_irq}, 64'd0);

        // atomic LO/HI read across a 32-bit carry
        wr_reg(3'd4, 32'd0);
        wr_reg(3'd5, 32'd0);
        wr_reg(3'd0, 32'hFFFF_FFFE);
        wr_reg(3'd1, 32'd0);
        wr_reg(3'd4, 32'd1);
        idle(1);
        rd_reg("wrap_lo", 3'd0, 32'hFFFF_FFFF);
        rd_reg("wrap_hi_shadow", 3'd1, 32'd0);
        rd_reg("post_wrap_lo", 3'd0, 32'd1);
        rd_reg("post_wrap_hi", 3'd1, 32'd1);

        // write collides with tick
        wr_reg(3'd0, 32'h55);
        rd_reg("collide_lo", 3'd0, 32'h55);
        rd_reg("collide_hi", 3'd1, 32'd1);

        // illegal accesses
        rd_any("byte_load", BASE, 3'b000, 32'd0, 1'b1);
        rd_reg("berr_set", 3'd6, 32'd3);
        rd_reg("ctrl_before", 3'd4, 32'd1);
        bus(1'b0, 1'b1, BASE + 32'h10, 32'd0, 3'b000);
        rd_reg("ctrl_byte_store", 3'd4, 32'd1);
        wr_reg(3'd6, 32'd2);
        rd_reg("berr_clear", 3'd6, 32'd1);
        rd_any("misaligned", BASE + 32'h6, 3'b010, 32'd0, 1'b1);
        rd_reg("berr_misalign", 3'd6, 32'd3);
        wr_reg(3'd6, 32'd2);
        rd_any("outside", 32'h0000_3000, 3'b010, 32'd0, 1'b0);
        rd_reg("berr_outside", 3'd6, 32'd1);

        // asynchronous reset mid-count
        @(posedge clk);
        #2 rst = 1'b1;
        rd_reg("rst_mtime", 3'd0, 32'd0);
        rd_reg("rst_cmp", 3'd2, 32'hFFFF_FFFF);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(5);
        rd_reg("post_rst_lo", 3'd0, 32'd0);
        rd_reg("post_rst_ctrl", 3'd4, 32'd0);
        wr_reg(3'd5, 32'd1);
        wr_reg(3'd4, 32'd1);
        idle(2);
        rd_reg("post_rst_tick", 3'd0, 32'd1);

        idle(2);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mtimer.md
# mtimer

Memory-mapped machine timer that responds to the core's data-memory access port (rd_en/wr_en/addr/wdata/mem_mode) alongside data_mem, decoding its own address window. It holds a 64-bit free-running mtime counter with programmable prescaler and a 64-bit mtimecmp compare register. It drives a registered machine-timer interrupt request to the CSR unit's MTIP input. Reads are combinational in the same cycle, like data_mem; writes and all counter state update on the rising clock edge.

## Interface
- BASE_ADDR, 32'h0000_2000: window base; 32-byte aligned (bits [4:0] zero).
- PRESC_W, 16: prescaler register/counter width.

- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- rd_en  input  1  load request from core.
- wr_en  input  1  store request from core.
- addr  input  32  byte address (ALU result).
- wdata  input  32  store data.
- mem_mode  input  3  access size, funct3 encoding; only 3'b010 (word) is legal here.
- hit  output  1  combinational: addr[31:5] == BASE_ADDR[31:5]; top level uses it to pick rdata over data_mem output.
- rdata  output  32  combinational read data.
- timer_irq  output  1  registered interrupt request to CSR MTIP.

## Operation
- Register map, offset = addr[4:0], word-aligned:
  - 0x00 MTIME_LO RW.
  - 0x04 MTIME_HI RW; reads return the shadow register.
  - 0x08 MTIMECMP_LO RW.
  - 0x0C MTIMECMP_HI RW.
  - 0x10 CTRL RW: bit0 EN, bit1 IE, others read 0.
  - 0x14 PRESC RW: [PRESC_W-1:0].
  - 0x18 STATUS: bit0 PEND RO = (mtime >= mtimecmp, unsigned 64-bit), bit1 BERR W1C.
  - 0x1C reserved: reads 0, writes ignored.
- Legal access: hit && mem_mode==3'b010 && addr[1:0]==0.
- Illegal access: hit && (rd_en||wr_en) but not legal. Required response: set BERR at the edge, ignore the write, drive rdata=0.
- rdata = register value when hit && rd_en && legal; otherwise 0.
- rd_en and wr_en both high: the write is performed; rdata still shows the pre-write value.
- Shadow: a legal read of MTIME_LO captures mtime[63:32] into the shadow at the edge. This makes a LO-then-HI read pair atomic.
- Prescaler counter pcnt, evaluated each edge:
  - EN=0: pcnt<=0, no tick.
  - EN=1 and pcnt==PRESC: pcnt<=0, tick (mtime<=mtime+1, 64-bit wrap from all-ones to 0).
  - EN=1 otherwise: pcnt<=pcnt+1.
- A write to PRESC or CTRL also clears pcnt.
- Collision: a write to MTIME_LO or MTIME_HI in a tick cycle takes the written word; the other word is held; the tick is dropped. pcnt still restarts.
- timer_irq <= IE && (mtime >= mtimecmp), computed from pre-edge register values. It deasserts once mtimecmp is raised above mtime or IE is cleared.
- Reset values:
  - mtime=0, shadow=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF.
  - CTRL=0, PRESC=0, pcnt=0, BERR=0, timer_irq=0.
  - hit and rdata follow inputs combinationally even in reset; rdata reads reset values.

## Timing
- Read latency 0 cycles (combinational). Write visible on the first read after the edge.
- With PRESC=N, after the edge that sets EN: mtime first reads 1 after N+1 further edges, then increments every N+1 cycles.
- PRESC=0: mtime increments every cycle.
- Interrupt latency: timer_irq rises on the edge after the one at which mtime >= mtimecmp first holds (PEND rises one cycle before timer_irq).
- Async reset mid-count clears all state immediately. The first tick after release needs a CTRL write plus N+1 edges.

## Test plan
- Reset, then read all 8 offsets -> 0, 0, FFFF_FFFF, FFFF_FFFF, 0, 0, 0, 0; timer_irq=0.
- PRESC=3, CTRL=1, then wait 12 cycles after the CTRL edge -> MTIME_LO=3; with PRESC=0, 10 cycles -> 10.
- mtimecmp={0,5}, CTRL=3, PRESC=0 -> PEND=1 when mtime=5; timer_irq high the next cycle. Write MTIMECMP_LO=100 -> timer_irq low one cycle later.
- Load mtime=0x0000_0000_FFFF_FFFE, run with EN=1, read LO (0xFFFF_FFFF) at the cycle before wrap, then read HI -> 0, not 1.
- Write MTIME_LO=0x55 on a tick cycle (PRESC=0) -> next read is 0x55 and HI is unchanged.
- Byte load (mem_mode=000) at BASE+0 -> rdata=0 and BERR=1; a byte store to CTRL does not change it; writing 2 to STATUS clears BERR. Assert rst mid-count -> mtime reads 0 immediately.
